// File: rtl/alarm_scanner.sv
// Alarm scanner: on each minute tick walks the alarm register file, compares every
// armed word against the latched time and handles ring, snooze, dismiss and timeout.
module alarm_scanner #(
  parameter int NUM_REGS   = 7,
  parameter int SNOOZE_MIN = 5,
  parameter int RING_MIN   = 10
) (
  input  logic        Clock,
  input  logic        Clear,
  input  logic        Enable,
  input  logic        Minute_Tick,
  input  logic [11:0] Cur_Time,
  output logic [2:0]  Rd_Sel,
  input  logic [12:0] Rd_Data,
  input  logic        Snooze,
  input  logic        Dismiss,
  output logic        Ring,
  output logic [2:0]  Alarm_Id,
  output logic        Busy
);

  localparam int CNT_MAX = (RING_MIN > SNOOZE_MIN) ? RING_MIN : SNOOZE_MIN;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [2:0]       LAST_SEL    = 3'(NUM_REGS - 1);
  localparam logic [CNT_W-1:0] RING_LOAD   = CNT_W'(RING_MIN);
  localparam logic [CNT_W-1:0] SNOOZE_LOAD = CNT_W'(SNOOZE_MIN);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, SCAN, RING, SNOOZE} state_t;

  state_t           state_q, state_d;
  logic [2:0]       rd_sel_q, rd_sel_d;
  logic [2:0]       alarm_id_q, alarm_id_d;
  logic [11:0]      time_q, time_d;
  logic [11:0]      pending_q, pending_d;
  logic             pending_vld_q, pending_vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Stored words with an out-of-range hour or minute can never ring.
  function automatic logic word_matches(input logic [12:0] word, input logic [11:0] t);
    logic valid;
    valid = (word[11:6] <= 6'd23) && (word[5:0] <= 6'd59);
    return word[12] && valid && (word[11:0] == t);
  endfunction

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state_q       <= IDLE;
      rd_sel_q      <= '0;
      alarm_id_q    <= '0;
      time_q        <= '0;
      pending_q     <= '0;
      pending_vld_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      rd_sel_q      <= rd_sel_d;
      alarm_id_q    <= alarm_id_d;
      time_q        <= time_d;
      pending_q     <= pending_d;
      pending_vld_q <= pending_vld_d;
      cnt_q         <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    rd_sel_d      = rd_sel_q;
    alarm_id_d    = alarm_id_q;
    time_d        = time_q;
    pending_d     = pending_q;
    pending_vld_d = pending_vld_q;
    cnt_d         = cnt_q;
    if (Enable) begin
      case (state_q)
        IDLE: begin
          if (Minute_Tick) begin
            time_d   = Cur_Time;
            rd_sel_d = '0;
            state_d  = SCAN;
          end
        end
        SCAN: begin
          if (Minute_Tick) begin
            pending_d     = Cur_Time;
            pending_vld_d = 1'b1;
          end
          if (word_matches(Rd_Data, time_q)) begin
            state_d       = RING;
            alarm_id_d    = rd_sel_q;
            cnt_d         = RING_LOAD;
            rd_sel_d      = '0;
            pending_vld_d = 1'b0;
          end else if (rd_sel_q == LAST_SEL) begin
            // A tick seen during this scan (even on its last cycle) chains a new scan.
            rd_sel_d      = '0;
            pending_vld_d = 1'b0;
            if (Minute_Tick)        time_d = Cur_Time;
            else if (pending_vld_q) time_d = pending_q;
            else                    state_d = IDLE;
          end else begin
            rd_sel_d = rd_sel_q + 3'd1;
          end
        end
        RING: begin
          if (Dismiss) begin
            state_d = IDLE;
          end else if (Snooze) begin
            state_d = SNOOZE;
            cnt_d   = SNOOZE_LOAD;
          end else if (Minute_Tick) begin
            if (cnt_q == CNT_LAST) state_d = IDLE;
            else                   cnt_d   = cnt_q - CNT_LAST;
          end
        end
        SNOOZE: begin
          if (Dismiss) begin
            state_d = IDLE;
          end else if (Minute_Tick) begin
            if (cnt_q == CNT_LAST) begin
              state_d = RING;
              cnt_d   = RING_LOAD;
            end else begin
              cnt_d = cnt_q - CNT_LAST;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign Rd_Sel   = rd_sel_q;
  assign Alarm_Id = alarm_id_q;
  assign Ring     = (state_q == RING);
  assign Busy     = (state_q == SCAN);

endmodule

// File: tb/tb_alarm_scanner.sv
// Bench for alarm_scanner: directed scenarios plus randomized traffic, all checked
// every cycle against a scan-outcome reference model.
module tb_alarm_scanner;

  localparam int NUM_REGS   = 7;
  localparam int SNOOZE_MIN = 5;
  localparam int RING_MIN   = 10;
  localparam logic [11:0] T0730 = 12'b000111_011110;
  localparam logic [12:0] A0730 = 13'b1_000111_011110;
  localparam logic [12:0] U0730 = 13'b0_000111_011110;
  localparam logic [11:0] T0800 = 12'b001000_000000;
  localparam logic [11:0] T0915 = 12'b001001_001111;
  localparam logic [11:0] T2500 = 12'b011001_000000;
  localparam int M_IDLE = 0, M_SCAN = 1, M_RING = 2, M_SNZ = 3;

  logic        Clock = 1'b0, Clear = 1'b0, Enable = 1'b0, Minute_Tick = 1'b0;
  logic        Snooze = 1'b0, Dismiss = 1'b0;
  logic [11:0] Cur_Time = '0;
  logic [2:0]  Rd_Sel, Alarm_Id;
  logic [12:0] Rd_Data;
  logic        Ring, Busy;
  logic [12:0] regs [0:7];

  int n_chk = 0, n_pass = 0;

  // model: mode, position in scan, precomputed first hit, id, minutes left
  int          m_mode, m_pos, m_hit, m_id, m_left;
  logic [11:0] m_time, m_pend_time;
  bit          m_pend;

  assign Rd_Data = regs[Rd_Sel];

  alarm_scanner #(.NUM_REGS(NUM_REGS), .SNOOZE_MIN(SNOOZE_MIN), .RING_MIN(RING_MIN)) dut (
    .Clock(Clock), .Clear(Clear), .Enable(Enable), .Minute_Tick(Minute_Tick),
    .Cur_Time(Cur_Time), .Rd_Sel(Rd_Sel), .Rd_Data(Rd_Data), .Snooze(Snooze),
    .Dismiss(Dismiss), .Ring(Ring), .Alarm_Id(Alarm_Id), .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
  endtask

  function automatic int first_hit(input logic [11:0] t);
    if (t[11:6] > 6'd23 || t[5:0] > 6'd59) return -1;
    for (int i = 0; i < NUM_REGS; i++)
      if (regs[i][12] && regs[i][11:0] == t) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_pos = 0; m_hit = -1; m_id = 0; m_left = 0;
    m_time = '0; m_pend_time = '0; m_pend = 0;
  endtask

  task automatic start_scan(input logic [11:0] t);
    m_mode = M_SCAN; m_pos = 0; m_time = t; m_hit = first_hit(t);
  endtask

  task automatic model_step();
    if (!Clear) begin
      model_reset();
    end else if (Enable) begin
      case (m_mode)
        M_IDLE: if (Minute_Tick) start_scan(Cur_Time);
        M_SCAN: begin
          if (Minute_Tick) begin m_pend = 1; m_pend_time = Cur_Time; end
          if (m_pos == m_hit) begin
            m_mode = M_RING; m_id = m_pos; m_left = RING_MIN; m_pos = 0; m_pend = 0;
          end else if (m_pos == NUM_REGS - 1) begin
            if (m_pend) begin m_pend = 0; start_scan(m_pend_time); end
            else begin m_mode = M_IDLE; m_pos = 0; end
          end else begin
            m_pos++;
          end
        end
        M_RING: begin
          if (Dismiss) m_mode = M_IDLE;
          else if (Snooze) begin m_mode = M_SNZ; m_left = SNOOZE_MIN; end
          else if (Minute_Tick) begin
            m_left--;
            if (m_left == 0) m_mode = M_IDLE;
          end
        end
        default: begin
          if (Dismiss) m_mode = M_IDLE;
          else if (Minute_Tick) begin
            m_left--;
            if (m_left == 0) begin m_mode = M_RING; m_left = RING_MIN; end
          end
        end
      endcase
    end
  endtask

  task automatic cycle();
    logic [7:0] e;
    @(posedge Clock);
    model_step();
    #1;
    e = {m_mode == M_RING, m_mode == M_SCAN, (m_mode == M_SCAN) ? 3'(m_pos) : 3'd0, 3'(m_id)};
    chk("cycle", {Ring, Busy, Rd_Sel, Alarm_Id}, e);
  endtask

  task automatic tick(input logic [11:0] t);
    Minute_Tick = 1'b1; Cur_Time = t;
    cycle();
    Minute_Tick = 1'b0;
  endtask

  task automatic dismiss();
    Dismiss = 1'b1; cycle(); Dismiss = 1'b0; cycle();
  endtask

  function automatic logic [11:0] rnd_time();
    logic [5:0] h, m;
    h = 6'($urandom_range(0, 26));
    m = ($urandom % 2) ? 6'($urandom_range(0, 3)) : 6'($urandom_range(57, 63));
    return {h, m};
  endfunction

  initial begin
    int n;
    for (int i = 0; i < 8; i++) regs[i] = '0;
    model_reset();
    Enable = 1'b1;
    repeat (2) @(posedge Clock);
    #1 chk("rst_out", {Ring, Busy, Rd_Sel, Alarm_Id}, 8'h00);
    Clear = 1'b1;

    // single match at index 2
    regs[2] = A0730;
    tick(T0730);
    chk("single_sel0", {Busy, Rd_Sel}, 4'b1_000);
    cycle(); cycle();
    chk("single_sel2", {Ring, Rd_Sel}, 4'b0_010);
    cycle();
    chk("single_ring", {Ring, Busy, Alarm_Id}, 5'b1_0_010);
    dismiss();

    // priority and invalid/unarmed words
    regs[0] = {1'b1, T2500}; regs[1] = A0730; regs[5] = A0730; regs[2] = '0;
    tick(T0730); cycle(); cycle();
    chk("prio_id", {Ring, Alarm_Id}, 4'b1_001);
    dismiss();
    tick(T2500); repeat (8) cycle();
    chk("invalid_nomatch", {Ring, Busy}, 2'b00);
    regs[1] = U0730; regs[5] = U0730;
    tick(T0730); repeat (8) cycle();
    chk("unarmed_nomatch", {Ring, Busy}, 2'b00);

    // snooze then ring timeout
    regs[2] = A0730;
    tick(T0730); repeat (3) cycle();
    chk("snz_ring", {Ring, Alarm_Id}, 4'b1_010);
    Snooze = 1'b1; cycle(); Snooze = 1'b0;
    chk("snz_quiet", Ring, 1'b0);
    repeat (SNOOZE_MIN - 1) begin tick(T0800); cycle(); end
    chk("snz_still", Ring, 1'b0);
    tick(T0800);
    chk("snz_rering", {Ring, Alarm_Id}, 4'b1_010);
    repeat (RING_MIN - 1) begin tick(T0800); cycle(); end
    chk("ring_before_to", Ring, 1'b1);
    tick(T0800);
    chk("ring_timeout", {Ring, Busy}, 2'b00);

    // snooze and dismiss together
    tick(T0730); repeat (3) cycle();
    chk("both_ring", Ring, 1'b1);
    Snooze = 1'b1; Dismiss = 1'b1; cycle(); Snooze = 1'b0; Dismiss = 1'b0;
    chk("both_off", Ring, 1'b0);
    repeat (SNOOZE_MIN) begin tick(T0800); repeat (8) cycle(); end
    chk("both_norering", {Ring, Busy}, 2'b00);

    // back-to-back ticks: pending scan uses the second time
    regs[4] = {1'b1, T0915};
    tick(T0800); cycle(); cycle();
    tick(T0915); repeat (3) cycle();
    chk("b2b_last", {Busy, Rd_Sel}, 4'b1_110);
    cycle();
    chk("b2b_restart", {Busy, Rd_Sel}, 4'b1_000);
    repeat (5) cycle();
    chk("b2b_ring", {Ring, Alarm_Id}, 4'b1_100);
    dismiss();

    // enable low mid-scan freezes the index
    tick(T0800); cycle();
    chk("en_sel1", Rd_Sel, 3'd1);
    Enable = 1'b0; repeat (4) cycle();
    chk("en_hold", {Busy, Rd_Sel}, 4'b1_001);
    Enable = 1'b1;
    n = 0;
    while (Busy && n < 20) begin cycle(); n++; end
    chk("en_delay", 32'(n), 32'd6);

    // async reset mid-scan
    tick(T0800); repeat (3) cycle();
    chk("rstm_sel3", Rd_Sel, 3'd3);
    #2 Clear = 1'b0;
    #1 model_reset();
    chk("rstm_out", {Ring, Busy, Rd_Sel, Alarm_Id}, 8'h00);
    Clear = 1'b1;
    repeat (5) cycle();
    chk("rstm_quiet", {Busy, Rd_Sel}, 4'b0_000);

    // randomized traffic
    for (int k = 0; k < 1500; k++) begin
      if (m_mode != M_SCAN && ($urandom % 30) == 0)
        for (int i = 0; i < 8; i++) regs[i] = {1'($urandom % 2), rnd_time()};
      Enable      = ($urandom % 10) != 0;
      Minute_Tick = ($urandom % 4) == 0;
      Cur_Time    = ($urandom % 2) ? regs[$urandom % NUM_REGS][11:0] : rnd_time();
      Snooze      = ($urandom % 12) == 0;
      Dismiss     = ($urandom % 25) == 0;
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
